// File: rtl/fifo_controller_if.sv
// Handshake and memory-side bundle for fifo_controller.
// Error-flag signals exist only when FIFO_ERROR_FLAGS_EN is defined.
interface fifo_controller_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 8
);
  logic                  iPush;
  logic                  iPop;
  logic [DATA_WIDTH-1:0] iDataIn;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [DATA_WIDTH-1:0] oDataToMem;
  logic                  oReadEnable;
  logic [ADDR_WIDTH-1:0] oReadAddress;
  logic                  oFull;
  logic                  oEmpty;
  logic                  oAlmostFull;
  logic                  oAlmostEmpty;
  logic [ADDR_WIDTH:0]   oCount;
  logic                  oDataValid;
`ifdef FIFO_ERROR_FLAGS_EN
  logic                  oOverflow;
  logic                  oUnderflow;
`endif

  modport slave (
    input  iPush, iPop, iDataIn,
    output oWriteEnable, oWriteAddress, oDataToMem,
    output oReadEnable, oReadAddress,
    output oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount, oDataValid
`ifdef FIFO_ERROR_FLAGS_EN
    , output oOverflow, oUnderflow
`endif
  );

  modport master (
    output iPush, iPop, iDataIn,
    input  oWriteEnable, oWriteAddress, oDataToMem,
    input  oReadEnable, oReadAddress,
    input  oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount, oDataValid
`ifdef FIFO_ERROR_FLAGS_EN
    , input oOverflow, oUnderflow
`endif
  );
endinterface

// File: rtl/fifo_controller.sv
// FIFO pointer/occupancy controller driving an external memory with registered read.
// Optional sticky overflow/underflow flags are built when FIFO_ERROR_FLAGS_EN is defined.
module fifo_controller #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 128
) (
  input logic               Clock,
  input logic               Reset,
  fifo_controller_if.slave  bus
);
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  dv_reg;
  logic                  push_ok;
  logic                  pop_ok;

  // Reset gates the enables so a request during reset never reaches the memory.
  assign push_ok = !Reset && bus.iPush && (state_reg != ST_FULL);
  assign pop_ok  = !Reset && bus.iPop  && (state_reg != ST_EMPTY);

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (push_ok)
      wptr_next = (wptr_reg == PTR_LAST) ? '0 : wptr_reg + PTR_ONE;
    if (pop_ok)
      rptr_next = (rptr_reg == PTR_LAST) ? '0 : rptr_reg + PTR_ONE;
    if (push_ok && !pop_ok)
      count_next = count_reg + CNT_ONE;
    else if (pop_ok && !push_ok)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_EMPTY;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      dv_reg    <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      dv_reg    <= pop_ok;
      case (state_reg)
        ST_EMPTY:   if (push_ok) state_reg <= ST_PARTIAL;
        ST_PARTIAL: begin
          if (count_next == CNT_FULL)      state_reg <= ST_FULL;
          else if (count_next == CNT_ZERO) state_reg <= ST_EMPTY;
        end
        ST_FULL:    if (pop_ok) state_reg <= ST_PARTIAL;
        default:    state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign bus.oWriteEnable  = push_ok;
  assign bus.oReadEnable   = pop_ok;
  assign bus.oWriteAddress = wptr_reg;
  assign bus.oReadAddress  = rptr_reg;
  assign bus.oDataToMem    = bus.iDataIn;
  assign bus.oCount        = count_reg;
  assign bus.oDataValid    = dv_reg;
  assign bus.oFull         = (count_reg == CNT_FULL);
  assign bus.oEmpty        = (count_reg == CNT_ZERO);
  assign bus.oAlmostFull   = (count_reg >= CNT_AF);
  assign bus.oAlmostEmpty  = (count_reg <= CNT_ONE);

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.iPush && state_reg == ST_FULL)  overflow_reg  <= 1'b1;
      if (bus.iPop  && state_reg == ST_EMPTY) underflow_reg <= 1'b1;
    end
  end

  assign bus.oOverflow  = overflow_reg;
  assign bus.oUnderflow = underflow_reg;
`endif
endmodule

// File: tb/tb_fifo_controller.sv
// Scoreboarded bench for fifo_controller (DEPTH=4) with a behavioural memory on the memory ports.
module tb_fifo_controller;
  localparam int DW    = 6;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  fifo_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // Memory with registered read, addressed only by the DUT.
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] rd_data;
  always @(posedge clk) begin
    if (bus.oWriteEnable) mem[bus.oWriteAddress] <= bus.oDataToMem;
    if (bus.oReadEnable)  rd_data <= mem[bus.oReadAddress];
  end

  int errors = 0;
  int checks = 0;
  int mcount, mw, mr;
  bit mdv, movf, mudf;
  logic [DW-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit p, input bit q, input logic [DW-1:0] d);
    bit pa, po;
    @(negedge clk);
    rst = r; bus.iPush = p; bus.iPop = q; bus.iDataIn = d;
    #1;
    pa = !r && p && (mcount != DEPTH);
    po = !r && q && (mcount != 0);
    check("wen",    32'(bus.oWriteEnable),  32'(pa));
    check("ren",    32'(bus.oReadEnable),   32'(po));
    check("waddr",  32'(bus.oWriteAddress), 32'(mw));
    check("raddr",  32'(bus.oReadAddress),  32'(mr));
    check("wdata",  32'(bus.oDataToMem),    32'(d));
    check("count",  32'(bus.oCount),        32'(mcount));
    check("full",   32'(bus.oFull),         32'(mcount == DEPTH));
    check("empty",  32'(bus.oEmpty),        32'(mcount == 0));
    check("afull",  32'(bus.oAlmostFull),   32'(mcount >= DEPTH - 1));
    check("aempty", 32'(bus.oAlmostEmpty),  32'(mcount <= 1));
    check("dvalid", 32'(bus.oDataValid),    32'(mdv));
`ifdef FIFO_ERROR_FLAGS_EN
    check("ovf",    32'(bus.oOverflow),     32'(movf));
    check("udf",    32'(bus.oUnderflow),    32'(mudf));
`endif
    if (mdv && bus.oDataValid) begin
      if (sb.size() == 0) check("sb_underrun", 32'(1), 32'(0));
      else                check("rdata", 32'(rd_data), 32'(sb.pop_front()));
    end
    $display("cyc rst=%0b push=%0b pop=%0b din=%h count=%0d wen=%0b ren=%0b dv=%0b",
             r, p, q, d, bus.oCount, bus.oWriteEnable, bus.oReadEnable, bus.oDataValid);
    @(posedge clk);
    if (r) begin
      mcount = 0; mw = 0; mr = 0; mdv = 0; movf = 0; mudf = 0;
      sb.delete();
    end else begin
      if (p && mcount == DEPTH) movf = 1;
      if (q && mcount == 0)     mudf = 1;
      if (pa) begin
        sb.push_back(d);
        mw = (mw + 1) % DEPTH;
      end
      if (po) mr = (mr + 1) % DEPTH;
      mcount = mcount + int'(pa) - int'(po);
      mdv = po;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.iPush = 1'b0; bus.iPop = 1'b0; bus.iDataIn = '0;
    mcount = 0; mw = 0; mr = 0; mdv = 0; movf = 0; mudf = 0;
    @(posedge clk);
    // Second reset cycle carries a push that must be discarded.
    cycle(1, 1, 1, 6'h2a);
    cycle(0, 0, 0, 6'h00);
    // Fill, then one rejected push.
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, DW'(i));
    // Drain, then one rejected pop.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 6'h00);
    cycle(0, 0, 0, 6'h00);
    // Wrap: hold count at 2 with simultaneous push and pop.
    cycle(0, 1, 0, 6'h11);
    cycle(0, 1, 0, 6'h12);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, DW'(6'h13 + i));
    cycle(0, 0, 1, 6'h00);
    cycle(0, 0, 1, 6'h00);
    // Boundaries: push+pop while empty, then while full.
    cycle(0, 1, 1, 6'h21);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, DW'(6'h22 + i));
    cycle(0, 1, 1, 6'h3f);
    cycle(0, 0, 0, 6'h00);
    // Mid-operation reset at count 3, then first push lands at address 0.
    cycle(1, 0, 0, 6'h00);
    cycle(0, 1, 0, 6'h05);
    cycle(0, 0, 1, 6'h00);
    cycle(0, 0, 0, 6'h00);
    // Random traffic.
    for (int i = 0; i < 60; i++)
      cycle(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), DW'($urandom));
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 6'h00);
    cycle(0, 0, 0, 6'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
